// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash master and its helpers.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

    // Control/status register bit positions
    localparam int CS_BIT      = 0;
    localparam int BUSY_BIT    = 1;
    localparam int DONE_BIT    = 2;
    localparam int OVR_BIT     = 3;
    localparam int CLR_OVR_BIT = 1;

    localparam int DIV_MIN = 2;
    localparam int DIV_MAX = 255;

endpackage

// File: rtl/spi_flash_master_sync2.sv
// Two-flop synchronizer for asynchronous input pins (MISO, RTS, IR RX).
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_flash_master.sv
// Memory-mapped SPI mode-0 master for the configuration flash: one data and one
// control/status register, software-driven chip select, full-duplex byte transfers.
module spi_flash_master
    import spi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic        sel_data,
    input  logic        sel_ctrl,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    localparam int         DIV_C   = (DIV < DIV_MIN) ? DIV_MIN : ((DIV > DIV_MAX) ? DIV_MAX : DIV);
    localparam logic [7:0] HALF_M1 = 8'(DIV_C - 1);

    spi_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_q, rx_d;
    logic [2:0] bit_q, bit_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;

    logic       miso_s;
    logic       busy;
    logic       wr_data, wr_ctrl, rd_data;
    logic       phase_end;
    logic       unused_wdata_hi;

    sync2 u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (miso),
        .q_o   (miso_s)
    );

    assign busy      = (state_q != IDLE);
    assign wr_data   = io_wr & sel_data;
    assign wr_ctrl   = io_wr & sel_ctrl;
    assign rd_data   = io_rd & sel_data;
    assign phase_end = (cnt_q == 8'd0);
    // The data register is a byte; the upper write lanes carry nothing.
    assign unused_wdata_hi = ^wdata[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            shift_q <= 8'd0;
            rx_q    <= 8'd0;
            bit_q   <= 3'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = done_q;
        ovr_d   = ovr_q;

        // Read-clear first so a completion in the same cycle overrides it.
        if (rd_data) done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_data) begin
                    shift_d = wdata[7:0];
                    mosi_d  = wdata[7];
                    cnt_d   = HALF_M1;
                    bit_d   = 3'd0;
                    done_d  = 1'b0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    sck_d   = 1'b1;
                    cnt_d   = HALF_M1;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    sck_d   = 1'b0;
                    cnt_d   = HALF_M1;
                    shift_d = {shift_q[6:0], miso_s};
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = shift_q[6];
                        state_d = LOW;
                    end else begin
                        rx_d    = {shift_q[6:0], miso_s};
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_data && busy) ovr_d = 1'b1;

        if (wr_ctrl) begin
            if (busy) ovr_d = 1'b1;
            else      cs_n_d = wdata[CS_BIT];
            if (wdata[CLR_OVR_BIT]) ovr_d = 1'b0;
        end
    end

    always_comb begin
        rdata = 16'd0;
        if (sel_data) rdata = rdata | {8'd0, rx_q};
        if (sel_ctrl) begin
            rdata[CS_BIT]   = rdata[CS_BIT]   | cs_n_q;
            rdata[BUSY_BIT] = rdata[BUSY_BIT] | busy;
            rdata[DONE_BIT] = rdata[DONE_BIT] | done_q;
            rdata[OVR_BIT]  = rdata[OVR_BIT]  | ovr_q;
        end
    end

    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench for spi_flash_master: instance 0 runs with DIV=2, instance 1 with DIV=5.
module tb_spi_flash_master;

    logic        clk;
    logic        reset_v    [2];
    logic        io_wr_v    [2];
    logic        io_rd_v    [2];
    logic        sel_data_v [2];
    logic        sel_ctrl_v [2];
    logic [15:0] wdata_v    [2];
    logic [15:0] rdata_v    [2];
    logic        sck_v      [2];
    logic        mosi_v     [2];
    logic        miso_v     [2];
    logic        cs_n_v     [2];

    int vectors     = 0;
    int miscompares = 0;

    spi_flash_master #(.DIV(2)) dut_a (
        .clk(clk), .reset(reset_v[0]), .io_wr(io_wr_v[0]), .io_rd(io_rd_v[0]),
        .sel_data(sel_data_v[0]), .sel_ctrl(sel_ctrl_v[0]), .wdata(wdata_v[0]),
        .rdata(rdata_v[0]), .sck(sck_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]),
        .cs_n(cs_n_v[0])
    );

    spi_flash_master #(.DIV(5)) dut_b (
        .clk(clk), .reset(reset_v[1]), .io_wr(io_wr_v[1]), .io_rd(io_rd_v[1]),
        .sel_data(sel_data_v[1]), .sel_ctrl(sel_ctrl_v[1]), .wdata(wdata_v[1]),
        .rdata(rdata_v[1]), .sck(sck_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]),
        .cs_n(cs_n_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int d, input logic sd, input logic sc, output logic [15:0] val);
        sel_data_v[d] = sd;
        sel_ctrl_v[d] = sc;
        #1;
        val = rdata_v[d];
        sel_data_v[d] = 1'b0;
        sel_ctrl_v[d] = 1'b0;
    endtask

    task automatic ctrl_write(input int d, input logic [15:0] w);
        wdata_v[d] = w; sel_ctrl_v[d] = 1'b1; io_wr_v[d] = 1'b1;
        tick();
        io_wr_v[d] = 1'b0; sel_ctrl_v[d] = 1'b0;
    endtask

    task automatic data_read(input int d, output logic [15:0] val);
        sel_data_v[d] = 1'b1; io_rd_v[d] = 1'b1;
        #1;
        val = rdata_v[d];
        tick();
        io_rd_v[d] = 1'b0; sel_data_v[d] = 1'b0;
    endtask

    // inj_kind: 0 none, 1 data write, 2 ctrl write, 3 reset, 4 data read;
    // applied in the cycle whose closing edge is busy cycle number inj_at.
    task automatic run_byte(input int d, input logic [7:0] tx, input logic [7:0] rxm,
                            input int inj_at, input int inj_kind, input logic [15:0] inj_w,
                            output logic [7:0] seen, output int busy_cyc, output int bad_phase);
        int rises, falls, run, guard, div;
        logic prev, s;
        logic [15:0] st;
        div = (d == 0) ? 2 : 5;
        seen = 8'h00; rises = 0; falls = 0; run = 1; guard = 0;
        busy_cyc = 0; bad_phase = 0; prev = 1'b0;
        miso_v[d] = rxm[7];
        wdata_v[d] = {8'h00, tx}; sel_data_v[d] = 1'b1; io_wr_v[d] = 1'b1;
        tick();
        io_wr_v[d] = 1'b0; sel_data_v[d] = 1'b0;
        while (guard < 4000) begin
            peek(d, 1'b0, 1'b1, st);
            if (!st[1]) break;
            busy_cyc++;
            if (busy_cyc == inj_at) begin
                case (inj_kind)
                    1: begin wdata_v[d] = inj_w; sel_data_v[d] = 1'b1; io_wr_v[d] = 1'b1; end
                    2: begin wdata_v[d] = inj_w; sel_ctrl_v[d] = 1'b1; io_wr_v[d] = 1'b1; end
                    3: reset_v[d] = 1'b1;
                    4: begin sel_data_v[d] = 1'b1; io_rd_v[d] = 1'b1; end
                    default: ;
                endcase
            end
            tick();
            io_wr_v[d] = 1'b0; io_rd_v[d] = 1'b0; sel_data_v[d] = 1'b0;
            sel_ctrl_v[d] = 1'b0; reset_v[d] = 1'b0;
            s = sck_v[d];
            if (s != prev) begin
                if (run != div) bad_phase++;
                run = 1;
                if (s) begin
                    if (rises < 8) seen[7 - rises] = mosi_v[d];
                    rises++;
                end else begin
                    falls++;
                    if (falls < 8) miso_v[d] = rxm[7 - falls];
                end
            end else begin
                run++;
            end
            prev = s;
            guard++;
        end
    endtask

    logic [7:0]  seen;
    logic [15:0] val;
    int          bcyc, badp;
    logic [7:0]  b_tx [4] = '{8'h9F, 8'h00, 8'h00, 8'h00};
    logic [7:0]  b_rx [4] = '{8'hFF, 8'hEF, 8'h40, 8'h16};

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_v[d] = 1'b1; io_wr_v[d] = 1'b0; io_rd_v[d] = 1'b0;
            sel_data_v[d] = 1'b0; sel_ctrl_v[d] = 1'b0; wdata_v[d] = 16'h0000;
            miso_v[d] = 1'b0;
        end
        repeat (3) tick();
        reset_v[0] = 1'b0; reset_v[1] = 1'b0;
        tick();

        // Reset state
        chk("rst_sck", {15'd0, sck_v[0]}, 16'h0000);
        chk("rst_mosi", {15'd0, mosi_v[0]}, 16'h0000);
        chk("rst_cs_n", {15'd0, cs_n_v[0]}, 16'h0001);
        chk("rst_rdata_nosel", rdata_v[0], 16'h0000);
        peek(0, 1'b0, 1'b1, val); chk("rst_status", val, 16'h0001);
        peek(0, 1'b1, 1'b0, val); chk("rst_data", val, 16'h0000);
        peek(0, 1'b1, 1'b1, val); chk("rst_both_or", val, 16'h0001);
        peek(1, 1'b0, 1'b1, val); chk("rst_status_b", val, 16'h0001);

        // Single byte A5 out, 3C in
        ctrl_write(0, 16'h0000);
        chk("cs_low", {15'd0, cs_n_v[0]}, 16'h0000);
        run_byte(0, 8'hA5, 8'h3C, 0, 0, 16'h0, seen, bcyc, badp);
        chk("a5_mosi", {8'd0, seen}, 16'h00A5);
        chk("a5_busy_cycles", 16'(bcyc), 16'd32);
        chk("a5_phases", 16'(badp), 16'd0);
        chk("a5_mosi_hold", {15'd0, mosi_v[0]}, 16'h0001);
        peek(0, 1'b0, 1'b1, val); chk("a5_status", val, 16'h0004);
        peek(0, 1'b1, 1'b0, val); chk("a5_rx", val, 16'h003C);
        peek(0, 1'b1, 1'b1, val); chk("a5_both_or", val, 16'h003C | 16'h0004);

        // Overrun: data write 5 cycles into transfer
        run_byte(0, 8'hC3, 8'h96, 5, 1, 16'h00FF, seen, bcyc, badp);
        chk("ovr_mosi", {8'd0, seen}, 16'h00C3);
        chk("ovr_busy_cycles", 16'(bcyc), 16'd32);
        peek(0, 1'b0, 1'b1, val); chk("ovr_status", val, 16'h000C);
        peek(0, 1'b1, 1'b0, val); chk("ovr_rx", val, 16'h0096);
        ctrl_write(0, 16'h0002);
        peek(0, 1'b0, 1'b1, val); chk("ovr_cleared", val, 16'h0004);
        chk("ovr_cs_n", {15'd0, cs_n_v[0]}, 16'h0000);

        // Done clear race: data read on completion cycle
        run_byte(0, 8'h12, 8'hE7, 32, 4, 16'h0, seen, bcyc, badp);
        chk("race_busy_cycles", 16'(bcyc), 16'd32);
        peek(0, 1'b0, 1'b1, val); chk("race_done_kept", val, 16'h0004);
        data_read(0, val); chk("race_read_rx", val, 16'h00E7);
        peek(0, 1'b0, 1'b1, val); chk("race_done_cleared", val, 16'h0000);

        // CS while busy
        run_byte(0, 8'h7E, 8'h81, 8, 2, 16'h0001, seen, bcyc, badp);
        chk("csb_mosi", {8'd0, seen}, 16'h007E);
        chk("csb_cs_n_held", {15'd0, cs_n_v[0]}, 16'h0000);
        peek(0, 1'b0, 1'b1, val); chk("csb_status", val, 16'h000C);
        peek(0, 1'b1, 1'b0, val); chk("csb_rx", val, 16'h0081);
        ctrl_write(0, 16'h0001);
        chk("csb_cs_n_high", {15'd0, cs_n_v[0]}, 16'h0001);
        peek(0, 1'b0, 1'b1, val); chk("csb_status2", val, 16'h000D);
        ctrl_write(0, 16'h0002);
        peek(0, 1'b0, 1'b1, val); chk("csb_status3", val, 16'h0004);

        // Reset at cycle 10 of an 81 transfer
        run_byte(0, 8'h81, 8'hFF, 10, 3, 16'h0, seen, bcyc, badp);
        chk("rmid_busy_cycles", 16'(bcyc), 16'd10);
        chk("rmid_sck", {15'd0, sck_v[0]}, 16'h0000);
        chk("rmid_cs_n", {15'd0, cs_n_v[0]}, 16'h0001);
        chk("rmid_mosi", {15'd0, mosi_v[0]}, 16'h0000);
        peek(0, 1'b0, 1'b1, val); chk("rmid_status", val, 16'h0001);
        peek(0, 1'b1, 1'b0, val); chk("rmid_rx", val, 16'h0000);
        ctrl_write(0, 16'h0000);
        run_byte(0, 8'h81, 8'h42, 0, 0, 16'h0, seen, bcyc, badp);
        chk("rpost_mosi", {8'd0, seen}, 16'h0081);
        chk("rpost_busy_cycles", 16'(bcyc), 16'd32);
        peek(0, 1'b1, 1'b0, val); chk("rpost_rx", val, 16'h0042);
        peek(0, 1'b0, 1'b1, val); chk("rpost_status", val, 16'h0004);

        // DIV=5 back-to-back JEDEC ID read
        ctrl_write(1, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            run_byte(1, b_tx[i], b_rx[i], 0, 0, 16'h0, seen, bcyc, badp);
            chk($sformatf("jedec%0d_mosi", i), {8'd0, seen}, {8'd0, b_tx[i]});
            chk($sformatf("jedec%0d_phases", i), 16'(badp), 16'd0);
            chk($sformatf("jedec%0d_busy_cycles", i), 16'(bcyc), 16'd80);
            peek(1, 1'b1, 1'b0, val);
            chk($sformatf("jedec%0d_rx", i), val, {8'd0, b_rx[i]});
        end
        peek(1, 1'b0, 1'b1, val); chk("jedec_status", val, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_flash_master.md
# spi_flash_master

Memory-mapped SPI mode-0 master for the configuration flash pins (SCK, MOSI, MISO, CS). It sits on the registered IO bus next to the UART and replaces bit-banging of the flash pins through the misc.out port. Top-level address decode drives its two register selects. It returns a 16-bit read word that top ORs into the IO read-data mux.

## Interface
- `DIV`, default 2: clk cycles per SCK half-period; legal range 2..255.
- `clk` in 1: system clock (PLL output).
- `reset` in 1: synchronous, active-high.
- `io_wr` in 1: registered IO write strobe, one cycle.
- `io_rd` in 1: registered IO read strobe, one cycle.
- `sel_data` in 1: data register selected.
- `sel_ctrl` in 1: control/status register selected.
- `wdata` in 16: registered IO write data.
- `rdata` out 16: read word; zero when neither select is high.
- `sck` out 1: SPI clock; idles low.
- `mosi` out 1: serial data out, MSB first.
- `miso` in 1: serial data in, asynchronous pin.
- `cs_n` out 1: flash chip select, software controlled.

## Operation
- Reset values:
  - `sck`=0, `mosi`=0, `cs_n`=1.
  - State IDLE; busy=0, done=0, overrun=0, rx=8'h00.
  - `rdata`=0.
- Data write (`io_wr & sel_data`):
  - In IDLE: loads `wdata[7:0]` into the shift register, clears done, enters LOW. `wdata[15:8]` is ignored.
  - While busy: the write is ignored and overrun is set.
- Control write (`io_wr & sel_ctrl`):
  - `wdata[0]` goes to `cs_n`. While busy, the `cs_n` update is ignored and overrun is set.
  - `wdata[1]`=1 clears overrun. This clear is also honoured while busy.
- Read mux:
  - `sel_data`: `{8'd0, rx}`.
  - `sel_ctrl`: `{12'd0, overrun, done, busy, cs_n}`.
  - Both selects high: the two words are ORed.
- `io_rd & sel_data` clears done. If the same cycle is the transfer-completion cycle, set wins and done stays 1.
- FSM states:
  - IDLE.
  - LOW: `sck`=0 for DIV cycles, then go to HIGH.
  - HIGH: `sck`=1 for DIV cycles. On the last cycle, sample MISO into the LSB end of the shift register.
  - At the end of HIGH: if bit count < 7, increment it, shift `mosi` to the next bit, go to LOW. Otherwise go to IDLE, set done, copy the shift register to rx.
- `mosi` shows the current MSB while busy and holds the last bit value in IDLE.
- `miso` passes through a 2-flop synchronizer before sampling. DIV≥2 is required so the sampled value is at least one full cycle old relative to SCK rise.
- Transfers are full duplex. The byte received in rx is the MISO stream, first bit received in rx[7].
- Reset asserted mid-transfer: immediate return to reset values on the next edge; no partial rx update.

## Timing
- Data write accepted at edge N: busy=1, `mosi`=bit7 from N+1.
- First SCK rise at N+1+DIV.
- SCK period 2·DIV cycles; 8 rising edges per byte.
- Last SCK fall, busy→0, done→1, rx valid: all at edge N+1+16·DIV.
- A back-to-back data write is accepted in the cycle after busy falls. Gap between bytes is at least 1 cycle of SCK low.
- `rdata` is combinational from the selects and registered state. It is valid in the same cycle as `io_rd`, which matches the registered-IO read timing.
- `cs_n` changes at the edge after the control write; no automatic setup or hold insertion.

## Structure
- Shared package `spi_pkg`:
  - State enum `{IDLE, LOW, HIGH}`.
  - Control/status bit indices: CS=0, BUSY=1, DONE=2, OVR=3; CLR_OVR is write bit 1.
  - DIV legal-range constants.
- Sub-module `sync2`: a 2-flop synchronizer for `miso`, reusable for other async pins such as RTS and IR RX.
- Single half-period counter (8 bits) plus a 3-bit bit counter; no separate divider module.

## Test plan
- **Single byte, DIV=2:** write ctrl 0 (cs_n low), write data 8'hA5, MISO model returns 8'h3C.
  - `mosi` sampled on SCK rises = 1,0,1,0,0,1,0,1.
  - busy high exactly 32 cycles; afterwards rx=8'h3C, status=4'b0100.
- **Overrun:** second data write 8'hFF issued 5 cycles into a transfer.
  - The transfer in flight completes with the original bits; overrun=1.
  - Ctrl write 2'b10 clears overrun to 0 while `cs_n` becomes 0.
- **Done clear race:** data read issued exactly on the completion cycle → done remains 1. Next data read → done=0, rdata=`{8'd0, rx}`.
- **Reset mid-transfer:** assert `reset` at cycle 10 of a 8'h81 transfer.
  - Next edge: `sck`=0, `cs_n`=1, busy=0, rx=0.
  - A subsequent 8'h81 transfer runs normally.
- **CS while busy:** ctrl write 1 during a transfer → `cs_n` stays 0 and overrun=1. Ctrl write 1 after busy falls → `cs_n`=1 at the next edge.
- **DIV=5 back-to-back:** bytes 8'h9F, 8'h00, 8'h00, 8'h00, each written on the first idle cycle.
  - SCK high and low phases are exactly 5 cycles.
  - JEDEC-ID model bytes EF 40 16 are returned in order.
